// File: rtl/rf_dump_streamer_if.sv
// Output stream of the register-file dump streamer: one byte per beat,
// tagged with the source address and an end-of-range flag.
interface rf_dump_streamer_if;
  logic [7:0] out_data;
  logic [2:0] out_addr;
  logic       out_last;
  logic       out_valid;
  logic       out_ready;

  modport master (
    output out_data,
    output out_addr,
    output out_last,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_addr,
    input  out_last,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/rf_dump_streamer.sv
// Walks a contiguous (possibly wrapping) address range through the 8x8
// register file's synchronous read port and streams each byte out with its
// address and a last flag. One byte takes ADDR, CAPTURE and SEND; SEND is
// the only state that waits on the consumer.
module rf_dump_streamer (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [2:0]                 first,
  input  logic [2:0]                 last,
  output logic [2:0]                 rf_addr,
  input  logic [7:0]                 rf_data,
  rf_dump_streamer_if.master         out_if,
  output logic                       busy,
  output logic                       done
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ADDR    = 3'd1,
    S_CAPTURE = 3'd2,
    S_SEND    = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] cur_q, cur_d;
  logic [2:0] end_q, end_d;
  logic [7:0] data_q, data_d;
  logic [2:0] oaddr_q, oaddr_d;
  logic       olast_q, olast_d;
  logic       valid_q, valid_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  // The read port always sees cur, so the address simply holds in IDLE.
  assign rf_addr          = cur_q;
  assign out_if.out_data  = data_q;
  assign out_if.out_addr  = oaddr_q;
  assign out_if.out_last  = olast_q;
  assign out_if.out_valid = valid_q;
  assign busy             = busy_q;
  assign done             = done_q;

  // Next-state and output-register logic for the dump walk.
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    end_d   = end_q;
    data_d  = data_q;
    oaddr_d = oaddr_q;
    olast_d = olast_q;
    valid_d = valid_q;

    unique case (state_q)
      S_IDLE: begin
        // Only IDLE samples start, so pulses while busy are dropped.
        if (start) begin
          cur_d   = first;
          end_d   = last;
          state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        // Register file samples rf_addr on this edge.
        state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        data_d  = rf_data;
        oaddr_d = cur_q;
        olast_d = (cur_q == end_q);
        valid_d = 1'b1;
        state_d = S_SEND;
      end
      S_SEND: begin
        // Payload is held untouched until the handshake.
        if (valid_q && out_if.out_ready) begin
          valid_d = 1'b0;
          if (cur_q == end_q) begin
            state_d = S_DONE;
          end else begin
            cur_d   = cur_q + 3'd1;  // wraps 7 -> 0
            state_d = S_ADDR;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        valid_d = 1'b0;
      end
    endcase

    // Status flags are decoded from the next state so they are registered.
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  // State and output registers; reset aborts any dump in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cur_q   <= 3'd0;
      end_q   <= 3'd0;
      data_q  <= 8'd0;
      oaddr_q <= 3'd0;
      olast_q <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      end_q   <= end_d;
      data_q  <= data_d;
      oaddr_q <= oaddr_d;
      olast_q <= olast_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

endmodule
